trigger_txn_sequencer: RTL and testbench

- Upstream stage feeding the primary bus master (master 1) of the bridged system.
- Conditions the raw trigger button, then runs one write-then-readback transaction pair to a remote Bus B address through the master's command port.
- Compares the readback with the written byte, latches it onto the LEDs, and reports pass, mismatch or timeout status.

---
 rtl/seq_pkg.sv | 18 +
 rtl/btn_conditioner.sv | 46 ++++
 rtl/trigger_txn_sequencer.sv | 177 +++++++++++++++++
 tb/tb_trigger_txn_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types for the trigger-driven write/readback sequencer.
// FSM state encoding and command direction constants.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_WAIT,
    RD_REQ,
    RD_WAIT,
    CHECK,
    ERR
  } seq_state_t;

  localparam logic CMD_WRITE = 1'b1;
  localparam logic CMD_READ  = 1'b0;

endpackage

// File: rtl/btn_conditioner.sv
// Button conditioning: 2-FF synchroniser, saturating debounce counter,
// and a one-cycle pulse on the rising edge of the debounced level.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed,
  output logic rise_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[0], btn_in};
    cnt_d  = cnt_q;
    if (!sync_q[1]) begin
      cnt_d = '0;
    end else if (cnt_q != CMAX) begin
      cnt_d = cnt_q + 1'b1;
    end
    prev_d = pressed;
  end

  assign pressed    = (cnt_q == CMAX);
  assign rise_pulse = pressed & ~prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      prev_q <= prev_d;
    end
  end

endmodule

// File: rtl/trigger_txn_sequencer.sv
// One write-then-readback round per debounced button press, with
// readback compare, LED latch, pass counter and sticky error flags.
module trigger_txn_sequencer
  import seq_pkg::*;
#(
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               ADDR_W          = 12,
  parameter logic [ADDR_W-1:0] TARGET_ADDR    = 12'h801,
  parameter logic [7:0]       WDATA_INIT      = 8'hA5,
  parameter logic [7:0]       WDATA_STEP      = 8'h01,
  parameter int               TIMEOUT_CYCLES  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_trigger,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic              cmd_write,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_wdata,
  input  logic              rsp_valid,
  input  logic [7:0]        rsp_rdata,
  output logic [7:0]        leds,
  output logic              busy,
  output logic              done_pulse,
  output logic              mismatch,
  output logic              timeout_err,
  output logic [7:0]        round_count
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic btn_pressed, btn_rise, trig;

  btn_conditioner #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_trigger),
    .pressed   (btn_pressed),
    .rise_pulse(btn_rise)
  );

  assign trig = btn_rise & btn_pressed;

  seq_state_t        state_q, state_d;
  logic [7:0]        data_q, data_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_write_q, cmd_write_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]        cmd_wdata_q, cmd_wdata_d;
  logic [7:0]        leds_q, leds_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mism_q, mism_d;
  logic              tmo_err_q, tmo_err_d;
  logic [7:0]        rc_q, rc_d;

  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    tmo_d       = tmo_q;
    cmd_valid_d = cmd_valid_q;
    cmd_write_d = cmd_write_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    leds_d      = leds_q;
    done_d      = 1'b0;
    mism_d      = mism_q;
    tmo_err_d   = tmo_err_q;
    rc_d        = rc_q;
    unique case (state_q)
      IDLE: if (trig) begin
        state_d     = WR_REQ;
        cmd_valid_d = 1'b1;
        cmd_write_d = CMD_WRITE;
        cmd_addr_d  = TARGET_ADDR;
        cmd_wdata_d = data_q;
      end
      WR_REQ: if (cmd_ready) begin
        state_d     = WR_WAIT;
        cmd_valid_d = 1'b0;
        tmo_d       = '0;
      end
      WR_WAIT: begin
        if (rsp_valid) begin
          state_d     = RD_REQ;
          cmd_valid_d = 1'b1;
          cmd_write_d = CMD_READ;
        end else if (tmo_q == TMAX) begin
          state_d   = ERR;
          tmo_err_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      RD_REQ: if (cmd_ready) begin
        state_d     = RD_WAIT;
        cmd_valid_d = 1'b0;
        tmo_d       = '0;
      end
      RD_WAIT: begin
        if (rsp_valid) begin
          state_d = CHECK;
          leds_d  = rsp_rdata;
          done_d  = 1'b1;
        end else if (tmo_q == TMAX) begin
          state_d   = ERR;
          tmo_err_d = 1'b1;
          done_d    = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      CHECK: begin
        state_d = IDLE;
        if (leds_q == data_q) begin
          rc_d   = rc_q + 8'd1;
          data_d = data_q + WDATA_STEP;
        end else begin
          mism_d = 1'b1;
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      data_q      <= WDATA_INIT;
      tmo_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_write_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      leds_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mism_q      <= 1'b0;
      tmo_err_q   <= 1'b0;
      rc_q        <= '0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_write_q <= cmd_write_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      leds_q      <= leds_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mism_q      <= mism_d;
      tmo_err_q   <= tmo_err_d;
      rc_q        <= rc_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign cmd_write   = cmd_write_q;
  assign cmd_addr    = cmd_addr_q;
  assign cmd_wdata   = cmd_wdata_q;
  assign leds        = leds_q;
  assign busy        = busy_q;
  assign done_pulse  = done_q;
  assign mismatch    = mism_q;
  assign timeout_err = tmo_err_q;
  assign round_count = rc_q;

endmodule

// File: tb/tb_trigger_txn_sequencer.sv
// Bench for trigger_txn_sequencer: master model with a command
// scoreboard plus per-scenario end-of-round state checks.
module tb_trigger_txn_sequencer;

  typedef struct packed {
    logic        wr;
    logic [11:0] addr;
    logic [7:0]  data;
  } cmd_t;

  localparam logic [11:0] TADDR = 12'h801;

  logic        clk = 1'b0;
  logic        rst, btn, cmd_ready, rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        cmd_valid, cmd_write, busy, done_pulse;
  logic        mismatch, timeout_err;
  logic [11:0] cmd_addr;
  logic [7:0]  cmd_wdata, leds, round_count;

  trigger_txn_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .btn_trigger(btn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .leds       (leds),
    .busy       (busy),
    .done_pulse (done_pulse),
    .mismatch   (mismatch),
    .timeout_err(timeout_err),
    .round_count(round_count)
  );

  always #5 clk = ~clk;

  int   n_cmp = 0;
  int   n_bad = 0;
  cmd_t exp_q[$];
  logic [7:0] m_data = 8'hA5;
  logic [7:0] m_leds = 8'h00;
  logic [7:0] m_rc = 8'h00;
  logic       m_mm = 1'b0;
  logic       m_to = 1'b0;
  logic [7:0] mem = 8'h00;
  int   done_cnt = 0;
  bit   cv_seen = 0;
  bit   busy_seen = 0;

  always @(negedge clk) begin
    if (done_pulse) done_cnt++;
    if (cmd_valid) cv_seen = 1;
    if (busy) busy_seen = 1;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_data = 8'hA5; m_leds = 8'h00; m_rc = 8'h00;
    m_mm = 1'b0; m_to = 1'b0;
    exp_q.delete();
  endtask

  task automatic apply_reset;
    rst = 1'b1;
    repeat (3) step;
    rst = 1'b0;
    step;
    model_reset();
  endtask

  // Waits for a command, holds off ready 2 cycles, checks it against the
  // scoreboard head, then completes the handshake.
  task automatic take_cmd(output bit ok);
    int   n;
    cmd_t got, e;
    n = 0;
    while (!cmd_valid && n < 64) begin step; n++; end
    n_cmp++;
    if (!cmd_valid) begin
      n_bad++;
      $display("FAIL cmd_wait: cmd_valid=0 after %0d cycles, required 1", n);
      ok = 0;
      return;
    end
    step; step;
    got = cmd_t'({cmd_write, cmd_addr, cmd_wdata});
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL cmd_unexpected: got %h, none expected", got);
    end else begin
      e = exp_q.pop_front();
      if (!cmd_valid || got !== e) begin
        n_bad++;
        $display("FAIL cmd_fields: valid=%b got %h, required %h",
                 cmd_valid, got, e);
      end
    end
    if (cmd_write) mem = cmd_wdata;
    cmd_ready = 1'b1;
    step;
    cmd_ready = 1'b0;
    ok = 1;
  endtask

  task automatic respond(input logic [7:0] d);
    repeat (19) step;
    rsp_valid = 1'b1;
    rsp_rdata = d;
    step;
    rsp_valid = 1'b0;
    rsp_rdata = 8'h00;
  endtask

  // One full press: write, readback (optionally corrupted), release.
  task automatic press_round(input bit ovr, input logic [7:0] ov);
    bit ok;
    logic [7:0] rd;
    exp_q.push_back(cmd_t'({1'b1, TADDR, m_data}));
    exp_q.push_back(cmd_t'({1'b0, TADDR, m_data}));
    btn = 1'b1;
    take_cmd(ok);
    if (ok) respond(8'h00);
    if (ok) take_cmd(ok);
    rd = ovr ? ov : mem;
    if (ok) respond(rd);
    step; step;
    m_leds = rd;
    if (rd == m_data) begin
      m_rc   = m_rc + 8'd1;
      m_data = m_data + 8'h01;
    end else begin
      m_mm = 1'b1;
    end
    if (!ok) exp_q.delete();
    btn = 1'b0;
    repeat (6) step;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) step;
    n_cmp++;
    if ({cmd_valid, cmd_write, cmd_addr, cmd_wdata, leds, busy, done_pulse,
         mismatch, timeout_err, round_count} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: v=%b w=%b a=%h d=%h l=%h b=%b rc=%h, required all 0",
               cmd_valid, cmd_write, cmd_addr, cmd_wdata, leds, busy, round_count);
    end
    rst = 1'b0;
    repeat (2) step;
    n_cmp++;
    if ({cmd_valid, busy, leds, round_count} !== '0) begin
      n_bad++;
      $display("FAIL post_reset_idle: v=%b b=%b l=%h rc=%h, required 0",
               cmd_valid, busy, leds, round_count);
    end
  endtask

  task automatic test_bounce;
    cv_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 20; i++) begin
      btn = ~btn;
      repeat (5) step;
    end
    btn = 1'b0;
    repeat (30) step;
    n_cmp++;
    if (cv_seen !== 1'b0 || busy_seen !== 1'b0) begin
      n_bad++;
      $display("FAIL bounce: cmd_valid_seen=%b busy_seen=%b, required 0 0",
               cv_seen, busy_seen);
    end
  endtask

  task automatic test_clean_press;
    int d0;
    d0 = done_cnt;
    press_round(1'b0, 8'h00);
    n_cmp++;
    if (leds !== 8'hA5 || round_count !== 8'd1 || mismatch !== 1'b0 ||
        busy !== 1'b0 || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL clean_press: leds=%h rc=%0d mm=%b busy=%b dones=%0d, required a5 1 0 0 1",
               leds, round_count, mismatch, busy, done_cnt - d0);
    end
  endtask

  task automatic test_mismatch;
    int d0;
    apply_reset();
    d0 = done_cnt;
    press_round(1'b1, 8'h5A);
    n_cmp++;
    if (leds !== 8'h5A || mismatch !== 1'b1 || round_count !== 8'd0 ||
        done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL mismatch_round: leds=%h mm=%b rc=%0d dones=%0d, required 5a 1 0 1",
               leds, mismatch, round_count, done_cnt - d0);
    end
    press_round(1'b0, 8'h00);
    n_cmp++;
    if ({leds, round_count, mismatch, timeout_err} !== {m_leds, m_rc, m_mm, m_to}) begin
      n_bad++;
      $display("FAIL mismatch_retry: leds=%h rc=%0d mm=%b to=%b, required %h %0d %b %b",
               leds, round_count, mismatch, timeout_err, m_leds, m_rc, m_mm, m_to);
    end
  endtask

  task automatic test_timeout;
    bit ok;
    int n, d0;
    d0 = done_cnt;
    exp_q.push_back(cmd_t'({1'b1, TADDR, m_data}));
    btn = 1'b1;
    take_cmd(ok);
    cv_seen = 0;
    n = 0;
    while (!done_pulse && n < 4200) begin step; n++; end
    n_cmp++;
    if (n != 4096 || timeout_err !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_fire: cycles=%0d to=%b, required 4096 1", n, timeout_err);
    end
    step; step;
    m_to = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || cv_seen || leds !== m_leds || done_cnt != d0 + 1) begin
      n_bad++;
      $display("FAIL timeout_idle: busy=%b cv=%b leds=%h dones=%0d, required 0 0 %h 1",
               busy, cv_seen, leds, done_cnt - d0, m_leds);
    end
    btn = 1'b0;
    repeat (6) step;
    press_round(1'b0, 8'h00);
    n_cmp++;
    if ({leds, round_count, mismatch, timeout_err} !== {m_leds, m_rc, m_mm, m_to}) begin
      n_bad++;
      $display("FAIL timeout_recover: leds=%h rc=%0d mm=%b to=%b, required %h %0d %b %b",
               leds, round_count, mismatch, timeout_err, m_leds, m_rc, m_mm, m_to);
    end
  endtask

  task automatic test_reset_mid;
    bit ok;
    exp_q.push_back(cmd_t'({1'b1, TADDR, m_data}));
    exp_q.push_back(cmd_t'({1'b0, TADDR, m_data}));
    btn = 1'b1;
    take_cmd(ok);
    if (ok) respond(8'h00);
    if (ok) take_cmd(ok);
    repeat (5) step;
    rst = 1'b1;
    #1;
    n_cmp++;
    if (cmd_valid !== 1'b0 || busy !== 1'b0 || leds !== 8'h00 ||
        done_pulse !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid: v=%b busy=%b leds=%h done=%b, required 0 0 00 0",
               cmd_valid, busy, leds, done_pulse);
    end
    btn = 1'b0;
    repeat (3) step;
    rst = 1'b0;
    step;
    model_reset();
    press_round(1'b0, 8'h00);
    n_cmp++;
    if (leds !== 8'hA5 || round_count !== 8'd1 || mismatch !== 1'b0 ||
        timeout_err !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_mid_next: leds=%h rc=%0d mm=%b to=%b, required a5 1 0 0",
               leds, round_count, mismatch, timeout_err);
    end
  endtask

  task automatic test_wrap;
    apply_reset();
    for (int i = 0; i < 91; i++) press_round(1'b0, 8'h00);
    n_cmp++;
    if (leds !== 8'hFF || round_count !== 8'd91) begin
      n_bad++;
      $display("FAIL wrap_ff: leds=%h rc=%0d, required ff 91", leds, round_count);
    end
    press_round(1'b0, 8'h00);
    n_cmp++;
    if (leds !== 8'h00 || round_count !== 8'd92 || mismatch !== 1'b0) begin
      n_bad++;
      $display("FAIL wrap_00: leds=%h rc=%0d mm=%b, required 00 92 0",
               leds, round_count, mismatch);
    end
  endtask

  initial begin
    rst = 1'b1;
    btn = 1'b0;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 8'h00;
    test_reset();
    test_bounce();
    test_clean_press();
    test_mismatch();
    test_timeout();
    test_reset_mid();
    test_wrap();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d pending, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
